// File: rtl/booth_mul_sched_pkg.sv
// Shared types and default constants for the Booth multiplier scheduler.
package booth_sched_pkg;

    localparam int MUL_ITER_DEF = 32;
    localparam int W_DEF        = 32;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        LOAD,
        RUN,
        CAP,
        DONE
    } sched_state_t;

endpackage

// File: rtl/booth_mul_sched_if.sv
// Request/response bus between arithmetic clients (master) and the scheduler (slave).
interface booth_mul_sched_if
    import booth_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = W_DEF,
    localparam int IW   = $clog2(N_REQ)
) ();

    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ*W-1:0] req_m;
    logic [N_REQ*W-1:0] req_q;
    logic               resp_valid;
    logic               resp_ready;
    logic [IW-1:0]      resp_id;
    logic [2*W-1:0]     resp_p;

    modport master (
        output req_valid, req_m, req_q, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_p
    );

    modport slave (
        input  req_valid, req_m, req_q, resp_ready,
        output req_ready, resp_valid, resp_id, resp_p
    );

endinterface

// File: rtl/booth_mul_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, with wrap.
module rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int IW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    input  logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    gnt_idx
);

    logic          found;
    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    // ptr and k are both below N_REQ, so one conditional subtract wraps the sum
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(N_REQ)) begin
                sum = sum - (IW+1)'(N_REQ);
            end
            idx = sum[IW-1:0];
            if (en && !found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = idx;
            end
        end
    end

endmodule

// File: rtl/booth_mul_sched.sv
// Shares one sequential Booth multiplier core among N_REQ requesters, sequencing
// clear/load/run/capture per granted request and returning the product with its id.
module booth_mul_sched
    import booth_sched_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int W        = W_DEF,
    parameter int MUL_ITER = MUL_ITER_DEF,
    localparam int IW      = $clog2(N_REQ)
) (
    input  logic              clk,
    input  logic              reset,
    booth_mul_sched_if.slave  bus,
    output logic              mul_reset,
    output logic              mul_load,
    output logic [W-1:0]      mul_m,
    output logic [W-1:0]      mul_q,
    input  logic [2*W-1:0]    mul_p,
    output logic              busy
);

    localparam int CW = (MUL_ITER > 1) ? $clog2(MUL_ITER) : 1;

    sched_state_t   state_q, state_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [IW-1:0]  id_q, id_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   op_m_q, op_m_d;
    logic [W-1:0]   op_q_q, op_q_d;
    logic [2*W-1:0] prod_q, prod_d;

    logic [N_REQ-1:0] gnt;
    logic [IW-1:0]    gnt_idx;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req     (bus.req_valid),
        .ptr     (ptr_q),
        .en      (state_q == IDLE),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            op_m_q  <= '0;
            op_q_q  <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            op_m_q  <= op_m_d;
            op_q_q  <= op_q_d;
            prod_q  <= prod_d;
        end
    end

    // A grant is a handshake: the arbiter only picks requesters whose valid is set
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        op_m_d  = op_m_q;
        op_q_d  = op_q_q;
        prod_d  = prod_q;
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    id_d    = gnt_idx;
                    op_m_d  = bus.req_m[int'(gnt_idx)*W +: W];
                    op_q_d  = bus.req_q[int'(gnt_idx)*W +: W];
                    ptr_d   = (gnt_idx == IW'(N_REQ-1)) ? '0 : gnt_idx + IW'(1);
                    state_d = CLR;
                end
            end
            CLR:  state_d = LOAD;
            LOAD: begin
                cnt_d   = CW'(MUL_ITER-1);
                state_d = RUN;
            end
            RUN: begin
                if (cnt_q == '0) begin
                    state_d = CAP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            CAP: begin
                prod_d  = mul_p;
                state_d = DONE;
            end
            DONE: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready  = gnt;
    assign bus.resp_valid = (state_q == DONE);
    assign bus.resp_id    = id_q;
    assign bus.resp_p     = prod_q;

    // Reset also clears the core so an aborted run leaves nothing behind
    assign mul_reset = reset | (state_q == CLR);
    assign mul_load  = (state_q == LOAD);
    assign mul_m     = (state_q == IDLE) ? '0 : op_m_q;
    assign mul_q     = (state_q == IDLE) ? '0 : op_q_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_booth_mul_sched.sv
// Self-checking bench: transaction-level model of the scheduler plus a timed Booth core stand-in.
module tb_booth_mul_sched;
    import booth_sched_pkg::*;

    localparam int N_REQ    = 4;
    localparam int W        = 32;
    localparam int MUL_ITER = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic           mul_reset, mul_load, busy;
    logic [W-1:0]   mul_m, mul_q;
    logic [2*W-1:0] mul_p;

    booth_mul_sched_if #(.N_REQ(N_REQ), .W(W)) bus ();

    booth_mul_sched #(.N_REQ(N_REQ), .W(W), .MUL_ITER(MUL_ITER)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .mul_reset (mul_reset),
        .mul_load  (mul_load),
        .mul_m     (mul_m),
        .mul_q     (mul_q),
        .mul_p     (mul_p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Core stand-in: product appears only after MUL_ITER run cycles, zero before
    longint      core_pend = 0;
    int          core_cnt  = 0;
    logic [63:0] core_p    = '0;
    always @(posedge clk) begin
        if (mul_reset) begin
            core_p   <= '0;
            core_cnt <= 0;
        end else if (mul_load) begin
            core_pend <= longint'($signed(mul_m)) * longint'($signed(mul_q));
            core_cnt  <= MUL_ITER;
        end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) core_p <= core_pend;
        end
    end
    assign mul_p = core_p;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int          hs_id[$], hs_cyc[$], rsp_id[$], rsp_cyc[$], load_cyc[$];
    logic [63:0] rsp_p[$];

    bit          m_active = 1'b0;
    int          m_off    = 0;
    int          m_ptr    = 0;
    int          m_id     = 0;
    logic [W-1:0] m_m, m_q;
    logic [63:0] m_prod;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] v, input int p);
        logic [N_REQ-1:0] r;
        int i;
        r = '0;
        for (int k = 0; k < N_REQ; k++) begin
            i = (p + k) % N_REQ;
            if (v[i] && r == '0) r[i] = 1'b1;
        end
        return r;
    endfunction

    // Model state advances here too: inputs only change just after posedge
    always @(negedge clk) begin : compare
        logic [N_REQ-1:0] e_ready, hs_vec;
        logic             e_valid;
        int               g;
        cyc++;
        if (reset) begin
            checkOutput("mul_reset_during_reset", 64'(mul_reset), 64'd1);
            m_active = 1'b0;
            m_ptr    = 0;
        end else begin
            hs_vec = bus.req_ready & bus.req_valid;
            if (|hs_vec) begin
                g = 0;
                for (int i = 0; i < N_REQ; i++) if (hs_vec[i]) g = i;
                hs_id.push_back(g);
                hs_cyc.push_back(cyc);
            end
            if (bus.resp_valid && bus.resp_ready) begin
                rsp_id.push_back(int'(bus.resp_id));
                rsp_p.push_back(bus.resp_p);
                rsp_cyc.push_back(cyc);
            end
            if (mul_load) load_cyc.push_back(cyc);

            if (!m_active) begin
                e_ready = rr_pick(bus.req_valid, m_ptr);
                checkOutput("req_ready", 64'(bus.req_ready), 64'(e_ready));
                checkOutput("busy", 64'(busy), 64'd0);
                checkOutput("mul_reset", 64'(mul_reset), 64'd0);
                checkOutput("mul_load", 64'(mul_load), 64'd0);
                checkOutput("mul_m", 64'(mul_m), 64'd0);
                checkOutput("mul_q", 64'(mul_q), 64'd0);
                checkOutput("resp_valid", 64'(bus.resp_valid), 64'd0);
                if (|e_ready) begin
                    g = 0;
                    for (int i = 0; i < N_REQ; i++) if (e_ready[i]) g = i;
                    m_active = 1'b1;
                    m_off    = 1;
                    m_id     = g;
                    m_m      = bus.req_m[g*W +: W];
                    m_q      = bus.req_q[g*W +: W];
                    m_prod   = 64'(longint'($signed(m_m)) * longint'($signed(m_q)));
                    m_ptr    = (g + 1) % N_REQ;
                end
            end else begin
                e_valid = (m_off >= MUL_ITER + 4);
                checkOutput("req_ready", 64'(bus.req_ready), 64'd0);
                checkOutput("busy", 64'(busy), 64'd1);
                checkOutput("mul_reset", 64'(mul_reset), 64'(m_off == 1));
                checkOutput("mul_load", 64'(mul_load), 64'(m_off == 2));
                checkOutput("mul_m", 64'(mul_m), 64'(m_m));
                checkOutput("mul_q", 64'(mul_q), 64'(m_q));
                checkOutput("resp_valid", 64'(bus.resp_valid), 64'(e_valid));
                if (e_valid) begin
                    checkOutput("resp_id", 64'(bus.resp_id), 64'(m_id));
                    checkOutput("resp_p", bus.resp_p, m_prod);
                end
                if (e_valid && bus.resp_ready) m_active = 1'b0;
                else m_off++;
            end
        end
    end

    task automatic applyStimulus(input int idx, input logic v, input logic [W-1:0] m, input logic [W-1:0] q);
        bus.req_valid[idx]      = v;
        bus.req_m[idx*W +: W]   = m;
        bus.req_q[idx*W +: W]   = q;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        next_cycle();
    endtask

    task automatic wait_hs(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (hs_id.size() >= n) begin
                ok = 1'b1;
                break;
            end
            next_cycle();
        end
    endtask

    task automatic wait_rsp(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (rsp_id.size() >= n) begin
                ok = 1'b1;
                break;
            end
            next_cycle();
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit          ok, flag;
        int          hb, rb, lb;
        int          exp_ids[5];
        logic [63:0] exp_prod[5];

        reset          = 1'b1;
        bus.req_valid  = '0;
        bus.req_m      = '0;
        bus.req_q      = '0;
        bus.resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        checkOutput("rst_resp_p", bus.resp_p, 64'd0);
        checkOutput("rst_resp_id", 64'(bus.resp_id), 64'd0);
        checkOutput("rst_mul_load", 64'(mul_load), 64'd0);
        checkOutput("rst_mul_m", 64'(mul_m), 64'd0);

        $display("[TB] idle for 50 cycles");
        flag = 1'b0;
        repeat (50) begin
            @(negedge clk);
            flag |= mul_reset | mul_load | busy | (|mul_m) | (|mul_q) | (|bus.req_ready);
        end
        checkOutput("idle_quiet", 64'(flag), 64'd0);
        next_cycle();

        $display("[TB] single request from requester 2");
        hb = hs_id.size(); rb = rsp_id.size(); lb = load_cyc.size();
        bus.resp_ready = 1'b1;
        applyStimulus(2, 1'b1, 32'd7, 32'hFFFF_FFFD);
        wait_hs(hb + 1, ok);
        checkOutput("single_hs_wait", 64'(ok), 64'd1);
        applyStimulus(2, 1'b0, '0, '0);
        wait_rsp(rb + 1, ok);
        checkOutput("single_rsp_wait", 64'(ok), 64'd1);
        if (ok) begin
            checkOutput("single_id", 64'(rsp_id[rb]), 64'd2);
            checkOutput("single_p", rsp_p[rb], 64'hFFFF_FFFF_FFFF_FFEB);
            checkOutput("single_latency", 64'(rsp_cyc[rb] - hs_cyc[hb]), 64'd36);
            checkOutput("single_load_count", 64'(load_cyc.size() - lb), 64'd1);
            checkOutput("single_load_cycle", 64'(load_cyc[lb] - hs_cyc[hb]), 64'd2);
        end

        $display("[TB] all four requesters valid");
        pulse_reset();
        hb = hs_id.size(); rb = rsp_id.size();
        applyStimulus(0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        applyStimulus(1, 1'b1, 32'h7FFF_FFFF, 32'd2);
        applyStimulus(2, 1'b1, 32'd123, -32'sd456);
        applyStimulus(3, 1'b1, -32'sd1000, 32'd1000);
        exp_ids  = '{0, 1, 2, 3, 0};
        exp_prod = '{64'd1, 64'h0000_0000_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_24E8,
                     64'hFFFF_FFFF_FFF0_BDC0, 64'd1};
        wait_rsp(rb + 5, ok);
        for (int i = 0; i < N_REQ; i++) applyStimulus(i, 1'b0, '0, '0);
        checkOutput("rr_rsp_wait", 64'(ok), 64'd1);
        if (ok) begin
            for (int i = 0; i < 5; i++) begin
                checkOutput($sformatf("rr_id%0d", i), 64'(rsp_id[rb+i]), 64'(exp_ids[i]));
                checkOutput($sformatf("rr_p%0d", i), rsp_p[rb+i], exp_prod[i]);
            end
            checkOutput("rr_issue_interval", 64'(hs_cyc[hb+1] - hs_cyc[hb]), 64'd37);
        end
        repeat (3) next_cycle();

        $display("[TB] fairness between requesters 0 and 1");
        pulse_reset();
        hb = hs_id.size(); rb = rsp_id.size();
        applyStimulus(0, 1'b1, 32'd3, 32'd4);
        applyStimulus(1, 1'b1, -32'sd2, 32'd5);
        wait_rsp(rb + 4, ok);
        applyStimulus(0, 1'b0, '0, '0);
        applyStimulus(1, 1'b0, '0, '0);
        checkOutput("fair_rsp_wait", 64'(ok), 64'd1);
        if (ok) begin
            flag = 1'b0;
            for (int i = 0; i < 4; i++) begin
                checkOutput($sformatf("fair_id%0d", i), 64'(rsp_id[rb+i]), 64'(i % 2));
                if (i > 0 && rsp_id[rb+i] == 0 && rsp_id[rb+i-1] == 0) flag = 1'b1;
            end
            checkOutput("fair_no_double_0", 64'(flag), 64'd0);
            checkOutput("fair_p0", rsp_p[rb], 64'd12);
        end
        repeat (3) next_cycle();

        $display("[TB] backpressure in DONE");
        pulse_reset();
        hb = hs_id.size(); rb = rsp_id.size();
        bus.resp_ready = 1'b0;
        applyStimulus(3, 1'b1, -32'sd9, 32'd11);
        wait_hs(hb + 1, ok);
        checkOutput("bp_hs_wait", 64'(ok), 64'd1);
        applyStimulus(3, 1'b0, '0, '0);
        applyStimulus(0, 1'b1, 32'd2, 32'd3);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("bp_valid_wait", 64'(ok), 64'd1);
        flag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!bus.resp_valid || bus.resp_p !== 64'hFFFF_FFFF_FFFF_FF9D ||
                bus.resp_id !== 2'd3 || bus.req_ready !== '0) flag = 1'b1;
            @(negedge clk);
        end
        checkOutput("bp_stable", 64'(flag), 64'd0);
        checkOutput("bp_no_early_grant", 64'(hs_id.size() - hb), 64'd1);
        next_cycle();
        bus.resp_ready = 1'b1;
        wait_hs(hb + 2, ok);
        applyStimulus(0, 1'b0, '0, '0);
        checkOutput("bp_regrant_wait", 64'(ok), 64'd1);
        if (ok) checkOutput("bp_regrant_cycle", 64'(hs_cyc[hb+1] - rsp_cyc[rb]), 64'd1);
        wait_rsp(rb + 2, ok);
        checkOutput("bp_rsp_wait", 64'(ok), 64'd1);
        if (ok) begin
            checkOutput("bp_p", rsp_p[rb], 64'hFFFF_FFFF_FFFF_FF9D);
            checkOutput("bp_second_p", rsp_p[rb+1], 64'd6);
        end
        repeat (3) next_cycle();

        $display("[TB] reset in RUN cycle 10");
        hb = hs_id.size(); rb = rsp_id.size();
        applyStimulus(1, 1'b1, 32'd100, 32'd100);
        wait_hs(hb + 1, ok);
        checkOutput("mid_hs_wait", 64'(ok), 64'd1);
        applyStimulus(1, 1'b0, '0, '0);
        repeat (11) next_cycle();
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mid_mul_reset", 64'(mul_reset), 64'd1);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("mid_busy", 64'(busy), 64'd0);
        checkOutput("mid_resp_valid", 64'(bus.resp_valid), 64'd0);
        next_cycle();
        hb = hs_id.size();
        applyStimulus(0, 1'b1, 32'd5, 32'd6);
        applyStimulus(2, 1'b1, 32'd1, 32'd1);
        wait_hs(hb + 1, ok);
        applyStimulus(0, 1'b0, '0, '0);
        applyStimulus(2, 1'b0, '0, '0);
        checkOutput("mid_next_hs_wait", 64'(ok), 64'd1);
        if (ok) checkOutput("mid_ptr_reset", 64'(hs_id[hb]), 64'd0);
        wait_rsp(rb + 1, ok);
        checkOutput("mid_rsp_wait", 64'(ok), 64'd1);
        if (ok) begin
            checkOutput("mid_id", 64'(rsp_id[rb]), 64'd0);
            checkOutput("mid_p", rsp_p[rb], 64'd30);
        end
        repeat (5) next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
